// File: rtl/ab_guess_solver_if.sv
// ab_guess_solver_if: bundle between the automatic 1A2B guesser and the
// scoring datapath / game controller.
//   start        : begin a new game (driven by controller)
//   Anum, Bnum   : A/B score of the outstanding guess
//   score_valid  : Anum/Bnum valid
//   guess0..3    : current guess digits, guess0 most significant
//   guess_valid  : guess stable and awaiting a score
//   busy, solved, fail, try_count : game status
// master = the guesser, slave = the scoring/controller side.
interface ab_guess_solver_if;
  logic       start;
  logic [2:0] Anum;
  logic [2:0] Bnum;
  logic       score_valid;
  logic [3:0] guess0;
  logic [3:0] guess1;
  logic [3:0] guess2;
  logic [3:0] guess3;
  logic       guess_valid;
  logic       busy;
  logic       solved;
  logic       fail;
  logic [3:0] try_count;

  modport master (
    input  start, Anum, Bnum, score_valid,
    output guess0, guess1, guess2, guess3, guess_valid, busy, solved, fail, try_count
  );

  modport slave (
    output start, Anum, Bnum, score_valid,
    input  guess0, guess1, guess2, guess3, guess_valid, busy, solved, fail, try_count
  );
endinterface

// File: rtl/ab_guess_solver.sv
// ab_guess_solver: automatic guessing player for 1A2B (bulls and cows).
// Walks a base-10 odometer over 0000..9999 one candidate per cycle and issues
// the lowest candidate with distinct digits that reproduces every stored score.
// Ports:
//   clka  : clock, all state changes on the falling edge
//   reset : asynchronous active-high clear
//   bus   : ab_guess_solver_if.master (start, score in; guess and status out)
module ab_guess_solver #(
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic              clka,
  input  logic              reset,
  ab_guess_solver_if.master bus
);

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned SCORE_W = 3;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_WAIT, S_DONE, S_FAIL} state_t;
  // Index 0 is the most significant digit (c0 / guess0), index 3 the least.
  typedef logic [3:0][DIG_W-1:0] digits_t;

  // {A, B} score of x against y.
  function automatic logic [2*SCORE_W-1:0] score_f(input digits_t x, input digits_t y);
    logic [SCORE_W-1:0] a;
    logic [SCORE_W-1:0] b;
    logic               hit;
    a = '0;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      if (x[i] == y[i]) a = a + SCORE_W'(1);
      hit = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && x[i] == y[j]) hit = 1'b1;
      end
      if (hit) b = b + SCORE_W'(1);
    end
    return {a, b};
  endfunction

  function automatic logic distinct_f(input digits_t x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (x[i] == x[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Decimal odometer step; 9999 wraps to 0000.
  function automatic digits_t incr_f(input digits_t x);
    digits_t r;
    logic    carry;
    r     = x;
    carry = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (carry) begin
        if (r[i] == DIG_W'(9)) begin
          r[i] = '0;
        end else begin
          r[i]  = r[i] + DIG_W'(1);
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  digits_t            cand_q, cand_d;
  digits_t            guess_q, guess_d;
  logic               guess_valid_q, guess_valid_d;
  logic               busy_q, busy_d;
  logic               solved_q, solved_d;
  logic               fail_q, fail_d;
  logic [CNT_W-1:0]   try_count_q, try_count_d;
  digits_t            hist_g_q [MAX_TRIES];
  digits_t            hist_g_d [MAX_TRIES];
  logic [SCORE_W-1:0] hist_a_q [MAX_TRIES];
  logic [SCORE_W-1:0] hist_a_d [MAX_TRIES];
  logic [SCORE_W-1:0] hist_b_q [MAX_TRIES];
  logic [SCORE_W-1:0] hist_b_d [MAX_TRIES];
  logic               accept_c;

  // Candidate must have distinct digits and match every valid history entry.
  always_comb begin
    accept_c = distinct_f(cand_q);
    for (int unsigned k = 0; k < MAX_TRIES; k++) begin
      if (k < 32'(try_count_q) &&
          score_f(cand_q, hist_g_q[k]) != {hist_a_q[k], hist_b_q[k]}) begin
        accept_c = 1'b0;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    guess_d     = guess_q;
    solved_d    = solved_q;
    fail_d      = fail_q;
    try_count_d = try_count_q;
    hist_g_d    = hist_g_q;
    hist_a_d    = hist_a_q;
    hist_b_d    = hist_b_q;

    case (state_q)
      S_SEARCH: begin
        if (accept_c) begin
          guess_d = cand_q;
          state_d = S_WAIT;
        end else if (cand_q == {4{DIG_W'(9)}}) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          cand_d = incr_f(cand_q);
        end
      end
      S_WAIT: begin
        if (bus.score_valid) begin
          if (bus.Anum == SCORE_W'(4)) begin
            solved_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            for (int unsigned k = 0; k < MAX_TRIES; k++) begin
              if (k == 32'(try_count_q)) begin
                hist_g_d[k] = guess_q;
                hist_a_d[k] = bus.Anum;
                hist_b_d[k] = bus.Bnum;
              end
            end
            try_count_d = try_count_q + CNT_W'(1);
            if (try_count_d == CNT_W'(MAX_TRIES)) begin
              fail_d  = 1'b1;
              state_d = S_FAIL;
            end else begin
              cand_d  = incr_f(cand_q);
              state_d = S_SEARCH;
            end
          end
        end
      end
      S_IDLE, S_DONE, S_FAIL: ;
      default: state_d = S_IDLE;
    endcase

    // A new game overrides whatever else happened this cycle.
    if (bus.start) begin
      state_d     = S_SEARCH;
      cand_d      = '0;
      solved_d    = 1'b0;
      fail_d      = 1'b0;
      try_count_d = '0;
      hist_g_d    = '{default: '0};
      hist_a_d    = '{default: '0};
      hist_b_d    = '{default: '0};
    end

    guess_valid_d = (state_d == S_WAIT);
    busy_d        = (state_d == S_SEARCH) || (state_d == S_WAIT);
  end

  // State and output registers, falling-edge clocked.
  always_ff @(negedge clka or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      guess_q       <= '0;
      guess_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      solved_q      <= 1'b0;
      fail_q        <= 1'b0;
      try_count_q   <= '0;
      hist_g_q      <= '{default: '0};
      hist_a_q      <= '{default: '0};
      hist_b_q      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      guess_q       <= guess_d;
      guess_valid_q <= guess_valid_d;
      busy_q        <= busy_d;
      solved_q      <= solved_d;
      fail_q        <= fail_d;
      try_count_q   <= try_count_d;
      hist_g_q      <= hist_g_d;
      hist_a_q      <= hist_a_d;
      hist_b_q      <= hist_b_d;
    end
  end

  assign bus.guess0      = guess_q[0];
  assign bus.guess1      = guess_q[1];
  assign bus.guess2      = guess_q[2];
  assign bus.guess3      = guess_q[3];
  assign bus.guess_valid = guess_valid_q;
  assign bus.busy        = busy_q;
  assign bus.solved      = solved_q;
  assign bus.fail        = fail_q;
  assign bus.try_count   = try_count_q;

endmodule

// File: tb/tb_ab_guess_solver.sv
// tb_ab_guess_solver: bench for ab_guess_solver. Two instances share the clock:
// dut1 with MAX_TRIES=10 and dut2 with MAX_TRIES=2. A reference player works
// on plain integers 0..9999 and predicts every guess, its latency and status.
module tb_ab_guess_solver;

  logic clka = 1'b0;
  logic reset;
  always #5 clka = ~clka;

  ab_guess_solver_if if1 ();
  ab_guess_solver_if if2 ();

  ab_guess_solver #(.MAX_TRIES(10)) dut1 (.clka(clka), .reset(reset), .bus(if1.master));
  ab_guess_solver #(.MAX_TRIES(2))  dut2 (.clka(clka), .reset(reset), .bus(if2.master));

  int nvec = 0;
  int nerr = 0;
  int hg[$];
  int ha[$];
  int hb[$];

  function automatic int dig(input int x, input int i);
    int p;
    p = (i == 0) ? 1000 : (i == 1) ? 100 : (i == 2) ? 10 : 1;
    return (x / p) % 10;
  endfunction

  function automatic logic [9:0] digit_set(input int x);
    logic [9:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[dig(x, i)] = 1'b1;
    return m;
  endfunction

  // Score of two distinct-digit numbers: A by position, B = shared digits - A.
  function automatic void score_ref(input int x, input int y, output int a, output int b);
    a = 0;
    for (int i = 0; i < 4; i++) if (dig(x, i) == dig(y, i)) a++;
    b = $countones(digit_set(x) & digit_set(y)) - a;
  endfunction

  // Lowest number >= from with four distinct digits agreeing with all history.
  function automatic int next_cand(input int from);
    int a, b;
    bit ok;
    for (int c = from; c <= 9999; c++) begin
      ok = ($countones(digit_set(c)) == 4);
      for (int k = 0; k < hg.size() && ok; k++) begin
        score_ref(c, hg[k], a, b);
        if (a != ha[k] || b != hb[k]) ok = 0;
      end
      if (ok) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] to_vec(input int x);
    return {4'(dig(x, 0)), 4'(dig(x, 1)), 4'(dig(x, 2)), 4'(dig(x, 3))};
  endfunction

  function automatic logic [15:0] dut_guess(input int d);
    if (d == 1) return {if1.guess0, if1.guess1, if1.guess2, if1.guess3};
    return {if2.guess0, if2.guess1, if2.guess2, if2.guess3};
  endfunction

  // {guess_valid, busy, solved, fail, try_count}
  function automatic logic [7:0] dut_stat(input int d);
    if (d == 1) return {if1.guess_valid, if1.busy, if1.solved, if1.fail, if1.try_count};
    return {if2.guess_valid, if2.busy, if2.solved, if2.fail, if2.try_count};
  endfunction

  task automatic drive(input int d, input logic st, input logic sv, input logic [2:0] a,
                       input logic [2:0] b);
    if (d == 1) begin
      if1.start = st; if1.score_valid = sv; if1.Anum = a; if1.Bnum = b;
    end else begin
      if2.start = st; if2.score_valid = sv; if2.Anum = a; if2.Bnum = b;
    end
  endtask

  // Pulse start across one falling edge (E0); returns 1 ns after E0.
  task automatic start_game(input int d);
    @(posedge clka);
    drive(d, 1'b1, 1'b0, 3'd0, 3'd0);
    @(negedge clka);
    #1;
    drive(d, 1'b0, 1'b0, 3'd0, 3'd0);
  endtask

  // Count falling edges until guess_valid or fail is seen (bounded).
  task automatic wait_event(input int d, output int edges);
    logic [7:0] st;
    edges = 0;
    while (edges < 10005) begin
      @(negedge clka);
      #1;
      edges++;
      st = dut_stat(d);
      if (st[7] || st[4]) break;
    end
  endtask

  // Watch a finished game for a while: no new guess may appear.
  task automatic check_quiet(input int d, input string name);
    bit seen;
    seen = 0;
    repeat (30) begin
      @(negedge clka);
      #1;
      if (dut_stat(d)[7]) seen = 1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL %s_quiet: guess_valid seen after game end (got %0b want 0)", name, seen);
    end
  endtask

  // Play a whole game. mode 0: score against secret, 1: random scores, 2: always 0A0B.
  task automatic play(input int d, input int mode, input int secret, input int maxt,
                      input string name, output int last, output bit won);
    int cs, found, edges, a, b, tries;
    logic [7:0] st;
    hg.delete(); ha.delete(); hb.delete();
    cs = 0; tries = 0; won = 0; last = -1;
    start_game(d);
    forever begin
      found = next_cand(cs);
      wait_event(d, edges);
      st = dut_stat(d);
      if (found < 0) begin
        nvec++;
        if (edges !== 10000 - cs) begin
          nerr++;
          $display("FAIL %s_exhaust_latency: got %0d edges want %0d", name, edges, 10000 - cs);
        end
        nvec++;
        if (st !== {1'b0, 1'b0, 1'b0, 1'b1, 4'(tries)}) begin
          nerr++;
          $display("FAIL %s_exhaust_status: got %b want %b", name, st, {4'b0001, 4'(tries)});
        end
        break;
      end
      nvec++;
      if (edges !== found - cs + 1) begin
        nerr++;
        $display("FAIL %s_latency_try%0d: got %0d edges want %0d", name, tries, edges,
                 found - cs + 1);
      end
      nvec++;
      if (st !== {1'b1, 1'b1, 1'b0, 1'b0, 4'(tries)}) begin
        nerr++;
        $display("FAIL %s_wait_status_try%0d: got %b want %b", name, tries, st,
                 {4'b1100, 4'(tries)});
      end
      nvec++;
      if (dut_guess(d) !== to_vec(found)) begin
        nerr++;
        $display("FAIL %s_guess_try%0d: got %h want %h", name, tries, dut_guess(d),
                 to_vec(found));
      end
      last = found;
      case (mode)
        0:       score_ref(found, secret, a, b);
        1:       begin a = int'($urandom_range(0, 7)); b = int'($urandom_range(0, 7)); end
        default: begin a = 0; b = 0; end
      endcase
      drive(d, 1'b0, 1'b1, 3'(a), 3'(b));
      @(negedge clka);
      #1;
      drive(d, 1'b0, 1'b0, 3'd0, 3'd0);
      st = dut_stat(d);
      if (a == 4) begin
        won = 1;
        nvec++;
        if (st !== {1'b0, 1'b0, 1'b1, 1'b0, 4'(tries)}) begin
          nerr++;
          $display("FAIL %s_solved_status: got %b want %b", name, st, {4'b0010, 4'(tries)});
        end
        break;
      end
      hg.push_back(found); ha.push_back(a); hb.push_back(b);
      tries++;
      if (tries == maxt) begin
        nvec++;
        if (st !== {1'b0, 1'b0, 1'b0, 1'b1, 4'(tries)}) begin
          nerr++;
          $display("FAIL %s_max_tries_status: got %b want %b", name, st, {4'b0001, 4'(tries)});
        end
        break;
      end
      nvec++;
      if (st !== {1'b0, 1'b1, 1'b0, 1'b0, 4'(tries)}) begin
        nerr++;
        $display("FAIL %s_scored_status_try%0d: got %b want %b", name, tries, st,
                 {4'b0100, 4'(tries)});
      end
      cs = found + 1;
    end
    check_quiet(d, name);
    if (last >= 0) begin
      nvec++;
      if (dut_guess(d) !== to_vec(last)) begin
        nerr++;
        $display("FAIL %s_guess_hold: got %h want %h", name, dut_guess(d), to_vec(last));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1'b0, 1'b0, 3'd0, 3'd0);
    drive(2, 1'b0, 1'b0, 3'd0, 3'd0);
    #12;
    for (int d = 1; d <= 2; d++) begin
      nvec++;
      if (dut_stat(d) !== 8'h00) begin
        nerr++;
        $display("FAIL reset_status_dut%0d: got %b want 00000000", d, dut_stat(d));
      end
      nvec++;
      if (dut_guess(d) !== 16'h0000) begin
        nerr++;
        $display("FAIL reset_guess_dut%0d: got %h want 0000", d, dut_guess(d));
      end
    end
    @(posedge clka);
    reset = 1'b0;
  endtask

  task automatic test_exhaust();
    int last;
    bit won;
    play(1, 2, 0, 10, "exhaust", last, won);
    nvec++;
    if (dut_guess(1) !== 16'h4567) begin
      nerr++;
      $display("FAIL exhaust_last_guess: got %h want 4567", dut_guess(1));
    end
  endtask

  task automatic test_secret_7039();
    int last;
    bit won;
    play(1, 0, 7039, 10, "secret7039", last, won);
    nvec++;
    if ({dut_stat(1)[5], dut_guess(1)} !== {1'b1, 16'h7039}) begin
      nerr++;
      $display("FAIL secret7039_final: got solved=%b guess=%h want solved=1 guess=7039",
               dut_stat(1)[5], dut_guess(1));
    end
  endtask

  task automatic test_max_tries();
    int last;
    bit won;
    play(2, 0, 9876, 2, "maxtries", last, won);
    nvec++;
    if (dut_stat(2) !== 8'b0001_0010) begin
      nerr++;
      $display("FAIL maxtries_final: got %b want 00010010", dut_stat(2));
    end
  endtask

  task automatic test_random_secrets();
    int last, s, dg;
    bit won;
    logic [9:0] used;
    repeat (2) begin
      used = '0; s = 0;
      for (int i = 0; i < 4; i++) begin
        do dg = int'($urandom_range(0, 9)); while (used[dg]);
        used[dg] = 1'b1;
        s = s * 10 + dg;
      end
      play(1, 0, s, 10, "random_secret", last, won);
    end
  endtask

  task automatic test_random_scores();
    int last;
    bit won;
    repeat (2) play(2, 1, 0, 2, "random_scores", last, won);
  endtask

  task automatic test_reset_mid_wait();
    int edges;
    start_game(1);
    wait_event(1, edges);
    drive(1, 1'b0, 1'b1, 3'd0, 3'd0);
    @(negedge clka);
    #1;
    drive(1, 1'b0, 1'b0, 3'd0, 3'd0);
    wait_event(1, edges);
    @(posedge clka);
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if ({dut_stat(1), dut_guess(1)} !== 24'h0) begin
      nerr++;
      $display("FAIL reset_mid_wait: got stat=%b guess=%h want all 0", dut_stat(1),
               dut_guess(1));
    end
    #1;
    reset = 1'b0;
    start_game(1);
    wait_event(1, edges);
    nvec++;
    if ({edges, dut_guess(1), dut_stat(1)} !== {32'd124, 16'h0123, 8'b1100_0000}) begin
      nerr++;
      $display("FAIL reset_restart: got edges=%0d guess=%h stat=%b want 124 0123 11000000",
               edges, dut_guess(1), dut_stat(1));
    end
  endtask

  task automatic test_start_with_score();
    int edges;
    start_game(1);
    wait_event(1, edges);
    drive(1, 1'b0, 1'b1, 3'd0, 3'd0);
    @(negedge clka);
    #1;
    drive(1, 1'b0, 1'b0, 3'd0, 3'd0);
    wait_event(1, edges);
    drive(1, 1'b1, 1'b1, 3'd1, 3'd2);
    @(negedge clka);
    #1;
    drive(1, 1'b0, 1'b0, 3'd0, 3'd0);
    nvec++;
    if (dut_stat(1) !== 8'b0100_0000) begin
      nerr++;
      $display("FAIL start_priority_status: got %b want 01000000", dut_stat(1));
    end
    wait_event(1, edges);
    nvec++;
    if ({edges, dut_guess(1), dut_stat(1)} !== {32'd124, 16'h0123, 8'b1100_0000}) begin
      nerr++;
      $display("FAIL start_priority_reissue: got edges=%0d guess=%h stat=%b want 124 0123 11000000",
               edges, dut_guess(1), dut_stat(1));
    end
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_secret_7039();
    test_max_tries();
    test_random_secrets();
    test_random_scores();
    test_reset_mid_wait();
    test_start_with_score();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
